// File: rtl/scsa_pkg.sv
// Shared types and parameter checks for the speculative carry-select adder.
package scsa_pkg;

  // Result-path FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    FIX  = 2'd2
  } scsa_state_e;

  // Legal geometry: N splits evenly into at least two K-bit blocks
  function automatic bit scsa_params_ok(input int unsigned n, input int unsigned k);
    return (k > 0) && ((n % k) == 0) && (n >= 2 * k);
  endfunction

endpackage

// File: rtl/scsa_block.sv
// K-bit sub-adder: both carry-in variants plus block generate/propagate.
module scsa_block #(
  parameter int unsigned K = 4
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  output logic [K-1:0] sum0,
  output logic [K-1:0] sum1,
  output logic         g,
  output logic         p
);

  // Carry-out with cin 0 is the block generate
  assign {g, sum0} = {1'b0, a} + {1'b0, b};

  // Sum with cin 1; an all-ones sum0 means a carry-in would ripple through
  assign sum1 = sum0 + K'(1);
  assign p    = &sum0;

endmodule

// File: rtl/scsa_pipe_adder.sv
// Speculative carry-select approximate adder with optional one-cycle exact correction.
module scsa_pipe_adder
  import scsa_pkg::*;
#(
  parameter int unsigned N  = 16,
  parameter int unsigned K  = 4,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic          exact_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  sum,
  output logic          cout,
  output logic          err,
  output logic          corrected,
  output logic [CW-1:0] err_cnt,
  input  logic          err_cnt_clr
);

  localparam int unsigned M = N / K;
  localparam logic [CW-1:0] CNT_MAX = '1;

  // Reject geometries that do not split into whole blocks
  generate
    if (!scsa_params_ok(N, K)) begin : g_bad_params
      $error("scsa_pipe_adder: N must be a multiple of K and N >= 2*K");
    end
  endgenerate

  scsa_state_e state_q;

  logic [N-1:0]        a_q;
  logic [N-1:0]        b_q;

  logic [M-1:0]        blk_g;
  logic [M-1:0]        blk_p;
  logic [M-1:0][K-1:0] blk_sum0;
  logic [M-1:0][K-1:0] blk_sum1;

  logic [M-1:0]        spec_c;
  logic [M-1:0]        true_c;
  logic [N-1:0]        spec_sum_c;
  logic                spec_cout_c;
  logic                err_c;
  logic [N:0]          exact_c;

  logic                accept_c;
  logic                to_fix_c;
  logic                cnt_inc_c;

  // One sub-adder per K-bit slice of the operands
  generate
    for (genvar gi = 0; gi < int'(M); gi++) begin : g_blk
      scsa_block #(.K(K)) u_blk (
        .a    (a[gi*K +: K]),
        .b    (b[gi*K +: K]),
        .sum0 (blk_sum0[gi]),
        .sum1 (blk_sum1[gi]),
        .g    (blk_g[gi]),
        .p    (blk_p[gi])
      );
    end
  endgenerate

  // Speculative carry-select, true carry chain and mis-speculation detect
  always_comb begin
    logic carry;
    spec_c     = '0;
    true_c     = '0;
    spec_sum_c = '0;
    carry      = 1'b0;
    for (int unsigned i = 1; i < M; i++) begin
      spec_c[i] = blk_g[i-1];
      carry     = blk_g[i-1] | (blk_p[i-1] & carry);
      true_c[i] = carry;
    end
    for (int unsigned i = 0; i < M; i++) begin
      spec_sum_c[i*K +: K] = spec_c[i] ? blk_sum1[i] : blk_sum0[i];
    end
    spec_cout_c = blk_g[M-1] | (spec_c[M-1] & blk_p[M-1]);
    err_c       = |(spec_c ^ true_c);
  end

  // Exact sum of the held operands, used only by the correction cycle
  assign exact_c = {1'b0, a_q} + {1'b0, b_q};

  // Handshake and control decodes
  assign in_ready  = (state_q == IDLE) | ((state_q == HOLD) & out_ready);
  assign accept_c  = in_valid & in_ready;
  assign to_fix_c  = exact_mode & err_c;
  assign cnt_inc_c = (state_q == FIX) | (accept_c & err_c & ~exact_mode);

  // Result FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      err       <= 1'b0;
      corrected <= 1'b0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (accept_c) begin
            a_q <= a;
            b_q <= b;
            if (to_fix_c) begin
              state_q   <= FIX;
              out_valid <= 1'b0;
            end else begin
              state_q   <= HOLD;
              out_valid <= 1'b1;
              sum       <= spec_sum_c;
              cout      <= spec_cout_c;
              err       <= err_c;
              corrected <= 1'b0;
            end
          end else if ((state_q == HOLD) && out_ready) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
          end
        end
        FIX: begin
          state_q   <= HOLD;
          out_valid <= 1'b1;
          sum       <= exact_c[N-1:0];
          cout      <= exact_c[N];
          err       <= 1'b1;
          corrected <= 1'b1;
        end
        default: begin
          state_q   <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Saturating error counter; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_cnt_clr) begin
      err_cnt <= '0;
    end else if (cnt_inc_c && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_scsa_pipe_adder.sv
// Randomised and directed bench for scsa_pipe_adder against a transaction-level model.
module tb_scsa_pipe_adder;

  localparam int unsigned N   = 16;
  localparam int unsigned K   = 4;
  localparam int unsigned M   = N / K;
  localparam int unsigned CW  = 8;
  localparam int unsigned CW2 = 2;
  localparam int CNT_MAX  = (1 << CW) - 1;
  localparam int CNT_MAX2 = (1 << CW2) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           exact_mode;
  logic           out_ready;
  logic           err_cnt_clr;

  logic           in_ready,  in_ready2;
  logic           out_valid, out_valid2;
  logic [N-1:0]   sum,       sum2;
  logic           cout,      cout2;
  logic           err,       err2;
  logic           corrected, corrected2;
  logic [CW-1:0]  err_cnt;
  logic [CW2-1:0] err_cnt2;

  always #5 clk = ~clk;

  scsa_pipe_adder #(.N(N), .K(K), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .exact_mode(exact_mode), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .err(err),
    .corrected(corrected), .err_cnt(err_cnt), .err_cnt_clr(err_cnt_clr)
  );

  scsa_pipe_adder #(.N(N), .K(K), .CW(CW2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .exact_mode(exact_mode), .out_valid(out_valid2),
    .out_ready(out_ready), .sum(sum2), .cout(cout2), .err(err2),
    .corrected(corrected2), .err_cnt(err_cnt2), .err_cnt_clr(err_cnt_clr)
  );

  typedef struct {
    logic [N-1:0] sum;
    logic         cout;
    logic         err;
    logic         corrected;
  } res_t;

  int   checks   = 0;
  int   failures = 0;

  bit   m_valid  = 1'b0;
  bit   m_fix    = 1'b0;
  res_t m_res;
  res_t m_fix_res;
  int   m_cnt    = 0;
  int   m_cnt2   = 0;
  int   n_acc    = 0;
  int   n_del    = 0;
  int   n_drop   = 0;

  // Count one comparison and report it if it differs
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Speculative sum: each block guesses its carry-in from the block below alone
  function automatic logic [N:0] ref_approx(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N:0]  r;
    int unsigned mask, xs, ys, s, guess;
    r     = '0;
    mask  = (32'd1 << K) - 32'd1;
    guess = 0;
    for (int i = 0; i < int'(M); i++) begin
      xs = (32'(x) >> (i * K)) & mask;
      ys = (32'(y) >> (i * K)) & mask;
      s  = xs + ys + guess;
      r[i*K +: K] = K'(s);
      if (i == int'(M) - 1) r[N] = ((s >> K) & 32'd1) != 0;
      guess = (xs + ys) >> K;
    end
    return r;
  endfunction

  // Compare both DUTs against the model's view of the current cycle
  task automatic check_outputs(input bit exp_rdy);
    check_eq("in_ready",   32'(in_ready),   32'(exp_rdy));
    check_eq("in_ready2",  32'(in_ready2),  32'(exp_rdy));
    check_eq("out_valid",  32'(out_valid),  32'(m_valid));
    check_eq("out_valid2", 32'(out_valid2), 32'(m_valid));
    if (m_valid) begin
      check_eq("sum",        32'(sum),        32'(m_res.sum));
      check_eq("cout",       32'(cout),       32'(m_res.cout));
      check_eq("err",        32'(err),        32'(m_res.err));
      check_eq("corrected",  32'(corrected),  32'(m_res.corrected));
      check_eq("sum2",       32'(sum2),       32'(m_res.sum));
      check_eq("cout2",      32'(cout2),      32'(m_res.cout));
      check_eq("err2",       32'(err2),       32'(m_res.err));
      check_eq("corrected2", 32'(corrected2), 32'(m_res.corrected));
    end
    check_eq("err_cnt",  32'(err_cnt),  32'(m_cnt));
    check_eq("err_cnt2", 32'(err_cnt2), 32'(m_cnt2));
  endtask

  // Drive one cycle, check at the falling edge, advance the model, return #1 after the rising edge
  task automatic cycle(input bit v, input logic [N-1:0] aa, input logic [N-1:0] bb,
                       input bit em, input bit ordy, input bit clr, input bit r);
    bit         exp_rdy, acc, inc, e;
    logic [N:0] ex, ap;
    in_valid    = v;
    a           = aa;
    b           = bb;
    exact_mode  = em;
    out_ready   = ordy;
    err_cnt_clr = clr;
    rst         = r;
    @(negedge clk);
    exp_rdy = !m_fix && (!m_valid || ordy);
    check_outputs(exp_rdy);
    acc = v && exp_rdy;
    if (r) begin
      if (m_valid || m_fix) n_drop++;
      m_valid = 1'b0;
      m_fix   = 1'b0;
      m_cnt   = 0;
      m_cnt2  = 0;
    end else begin
      inc = 1'b0;
      if (m_valid && ordy) n_del++;
      if (m_fix) begin
        m_res   = m_fix_res;
        m_valid = 1'b1;
        m_fix   = 1'b0;
        inc     = 1'b1;
      end else if (acc) begin
        n_acc++;
        ex = {1'b0, aa} + {1'b0, bb};
        ap = ref_approx(aa, bb);
        e  = (ap[N-1:0] != ex[N-1:0]);
        if (em && e) begin
          m_fix     = 1'b1;
          m_valid   = 1'b0;
          m_fix_res = '{sum: ex[N-1:0], cout: ex[N], err: 1'b1, corrected: 1'b1};
        end else begin
          m_res   = '{sum: ap[N-1:0], cout: ap[N], err: e, corrected: 1'b0};
          m_valid = 1'b1;
          inc     = e;
        end
      end else if (m_valid && ordy) begin
        m_valid = 1'b0;
      end
      if (clr) begin
        m_cnt  = 0;
        m_cnt2 = 0;
      end else if (inc) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (m_cnt2 < CNT_MAX2) m_cnt2++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Directed scenarios followed by randomised traffic
  initial begin
    logic [N-1:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    exact_mode = 1'b0; out_ready = 1'b0; err_cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_sum",       32'(sum),       0);
    check_eq("rst_cout",      32'(cout),      0);
    check_eq("rst_err",       32'(err),       0);
    check_eq("rst_corrected", 32'(corrected), 0);
    check_eq("rst_err_cnt",   32'(err_cnt),   0);
    check_eq("rst_in_ready",  32'(in_ready),  1);

    // No error, approximate mode, one-cycle latency
    cycle(1, 16'h1234, 16'h1111, 0, 1, 0, 0);
    check_eq("t1_valid", 32'(out_valid), 1);
    check_eq("t1_sum",   32'(sum),       32'h2345);
    check_eq("t1_cout",  32'(cout),      0);
    check_eq("t1_err",   32'(err),       0);

    // Approximate mode with a mis-speculated carry
    cycle(1, 16'h00FF, 16'h0001, 0, 1, 0, 0);
    check_eq("t2_sum",  32'(sum),       32'h0000);
    check_eq("t2_err",  32'(err),       1);
    check_eq("t2_corr", 32'(corrected), 0);
    check_eq("t2_cnt",  32'(err_cnt),   1);

    // Exact mode: one bubble then the corrected sum
    cycle(1, 16'h00FF, 16'h0001, 1, 1, 0, 0);
    check_eq("t3_fix_valid", 32'(out_valid), 0);
    check_eq("t3_fix_ready", 32'(in_ready),  0);
    cycle(0, '0, '0, 0, 1, 0, 0);
    check_eq("t3_valid", 32'(out_valid), 1);
    check_eq("t3_sum",   32'(sum),       32'h0100);
    check_eq("t3_cout",  32'(cout),      0);
    check_eq("t3_err",   32'(err),       1);
    check_eq("t3_corr",  32'(corrected), 1);
    check_eq("t3_cnt",   32'(err_cnt),   2);

    // Corrected carry-out
    cycle(1, 16'hFFFF, 16'h0001, 1, 1, 0, 0);
    cycle(0, '0, '0, 0, 1, 0, 0);
    check_eq("t4_sum",  32'(sum),       32'h0000);
    check_eq("t4_cout", 32'(cout),      1);
    check_eq("t4_corr", 32'(corrected), 1);

    // Five errors in total: narrow counter saturates at 3
    cycle(1, 16'h00FF, 16'h0001, 0, 1, 0, 0);
    cycle(1, 16'h0FF0, 16'h0010, 0, 1, 0, 0);
    check_eq("t5_cnt",  32'(err_cnt),  5);
    check_eq("t5_cnt2", 32'(err_cnt2), 3);

    // Clear together with a new error gives zero
    cycle(1, 16'h00FF, 16'h0001, 0, 1, 1, 0);
    check_eq("t6_cnt",  32'(err_cnt),  0);
    check_eq("t6_cnt2", 32'(err_cnt2), 0);

    // Back-to-back accepts, then consumer stalls for three cycles
    for (int i = 0; i < 4; i++) cycle(1, N'(16'h1000 + i * 16'h0101), 16'h0123, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 16'h4444, 16'h1111, 0, 0, 0, 0);
      check_eq("stall_ready", 32'(in_ready), 0);
    end
    cycle(1, 16'h4444, 16'h1111, 0, 1, 0, 0);
    cycle(0, '0, '0, 0, 1, 0, 0);

    // Reset while a correction is pending drops it
    cycle(1, 16'h00FF, 16'h0001, 1, 1, 0, 0);
    cycle(0, '0, '0, 0, 1, 0, 1);
    check_eq("t7_valid", 32'(out_valid), 0);
    check_eq("t7_ready", 32'(in_ready),  1);
    check_eq("t7_sum",   32'(sum),       0);
    check_eq("t7_corr",  32'(corrected), 0);
    for (int i = 0; i < 3; i++) cycle(0, '0, '0, 0, 1, 0, 0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      if ($urandom_range(0, 2) == 0) rb = N'(~ra + N'($urandom_range(0, 20)));
      cycle($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
            $urandom_range(0, 255) == 0);
    end

    // Full-width counter saturation
    for (int i = 0; i < 260; i++) cycle(1, 16'h00FF, 16'h0001, 0, 1, 0, 0);
    check_eq("sat_cnt", 32'(err_cnt), 32'(CNT_MAX));

    // Drain and account for every accepted operand pair
    for (int i = 0; i < 4; i++) cycle(0, '0, '0, 0, 1, 0, 0);
    check_eq("no_loss", 32'(n_acc), 32'(n_del + n_drop));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
